// File: rtl/decoder_scanner_if.sv
// Control/status bundle between a scan controller and the decoder scanner.
// The master drives run requests; the scanner (slave) returns address, enable and status.
interface decoder_scanner_if #(
  parameter int N = 2
);
  logic         ena;
  logic         oneshot;
  logic [N-1:0] a;
  logic         en;
  logic         frame_done;
  logic         busy;

  modport master (
    output ena,
    output oneshot,
    input  a,
    input  en,
    input  frame_done,
    input  busy
  );

  modport slave (
    input  ena,
    input  oneshot,
    output a,
    output en,
    output frame_done,
    output busy
  );
endinterface

// File: rtl/decoder_scanner.sv
// Walks a downstream N-bit decoder through all 2^N addresses, holding enable high for
// DWELL cycles per address with BLANK idle cycles in between; every output is a flop.
module decoder_scanner #(
  parameter int N     = 2,
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic            clk,
  input  logic            rst,
  decoder_scanner_if.slave bus
);

  localparam int MAXP = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXP) + 1;

  generate
    if (N < 1 || N > 8) begin : g_bad_n
      $error("decoder_scanner: N must be in 1..8");
    end
    if (DWELL < 1) begin : g_bad_dwell
      $error("decoder_scanner: DWELL must be >= 1");
    end
    if (BLANK < 1) begin : g_bad_blank
      $error("decoder_scanner: BLANK must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [N-1:0]   a_reg, a_next;
  logic           en_reg, en_next;
  logic           done_reg, done_next;
  logic           busy_reg, busy_next;

  wire last_blank = (cnt_reg == CW'(BLANK - 1));
  wire last_dwell = (cnt_reg == CW'(DWELL - 1));
  wire last_addr  = (a_reg == {N{1'b1}});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      en_reg    <= 1'b0;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      en_reg    <= en_next;
      done_reg  <= done_next;
      busy_reg  <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    a_next     = a_reg;
    done_next  = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.ena) begin
          state_next = ST_BLANK;
          a_next     = '0;
          cnt_next   = '0;
        end
      end

      ST_BLANK: begin
        if (!bus.ena) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (last_blank) begin
          state_next = ST_DRIVE;
          cnt_next   = '0;
        end else begin
          cnt_next   = cnt_reg + CW'(1);
        end
      end

      ST_DRIVE: begin
        // ena is ignored mid-row so the dwell is never truncated.
        if (last_dwell) begin
          cnt_next = '0;
          if (last_addr) begin
            done_next = 1'b1;
            if (bus.ena && !bus.oneshot) begin
              state_next = ST_BLANK;
              a_next     = '0;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (bus.ena) begin
            state_next = ST_BLANK;
            a_next     = a_reg + N'(1);
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase

    // Enable and busy are registered copies of the upcoming state.
    en_next   = (state_next == ST_DRIVE);
    busy_next = (state_next != ST_IDLE);
  end

  assign bus.a          = a_reg;
  assign bus.en         = en_reg;
  assign bus.frame_done = done_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_decoder_scanner.sv
// Directed and randomized checks of decoder_scanner against a run-position model:
// outputs are derived from the number of cycles elapsed since the scan started.
module tb_decoder_scanner;
  localparam int N     = 2;
  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int R     = DWELL + BLANK;
  localparam int M     = 1 << N;

  logic clk = 1'b0;
  logic rst = 1'b0;

  decoder_scanner_if #(.N(N)) bus ();

  decoder_scanner #(.N(N), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model: p counts cycles since the run began; row = p / R, offset = p % R.
  bit running = 1'b0;
  int p       = 0;
  int a_m     = 0;
  bit done_m  = 1'b0;

  logic [N-1:0] prev_a = '0;
  int cyc           = 0;
  int last_done_cyc = -1;
  int n_pulses      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    running = 1'b0;
    p       = 0;
    a_m     = 0;
    done_m  = 1'b0;
  endtask

  task automatic model_edge(input bit e, input bit o);
    int off;
    int row;
    bit last;
    done_m = 1'b0;
    if (!running) begin
      if (e) begin
        running = 1'b1;
        p       = 0;
      end
    end else begin
      off = p % R;
      row = p / R;
      if (off < BLANK && !e) begin
        running = 1'b0;
      end else if (off == R - 1) begin
        last = ((row % M) == M - 1);
        if (last) done_m = 1'b1;
        if (e && !(last && o)) p++;
        else running = 1'b0;
      end else begin
        p++;
      end
    end
    if (running) a_m = (p / R) % M;
  endtask

  task automatic check_all();
    bit en_exp;
    en_exp = running && ((p % R) >= BLANK);
    chk("a",          32'(bus.a),          32'(a_m));
    chk("en",         32'(bus.en),         32'(en_exp));
    chk("busy",       32'(bus.busy),       32'(running));
    chk("frame_done", 32'(bus.frame_done), 32'(done_m));
    if (bus.en === 1'b1) chk("a_stable_while_en", 32'(bus.a), 32'(prev_a));
    if (bus.frame_done === 1'b1) begin
      n_pulses++;
      if (last_done_cyc >= 0) chk("frame_period", 32'(cyc - last_done_cyc), 32'(M * R));
      last_done_cyc = cyc;
    end
    prev_a = bus.a;
  endtask

  task automatic step(input bit e, input bit o);
    bus.ena     = e;
    bus.oneshot = o;
    if (!e || o) last_done_cyc = -1;
    @(posedge clk);
    model_edge(e, o);
    cyc++;
    @(negedge clk);
    check_all();
  endtask

  // Called at a falling edge: pulses reset strictly between rising edges.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    model_reset();
    last_done_cyc = -1;
    check_all();
    #2;
    rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < R + 1; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    bus.ena     = 1'b0;
    bus.oneshot = 1'b0;
    @(negedge clk);
    model_reset();
    check_all();
    #2 rst = 1'b1;

    // Idle after reset until ena arrives.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);

    // Continuous scan: frame_done every M*R cycles.
    n_pulses = 0;
    for (int i = 0; i < 45; i++) step(1'b1, 1'b0);
    chk("continuous_pulses", 32'(n_pulses), 32'd2);
    drain();

    // One-shot frame.
    n_pulses = 0;
    for (int i = 0; i < M * R; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("oneshot_pulses", 32'(n_pulses), 32'd1);
    chk("oneshot_a_held", 32'(bus.a), 32'(M - 1));
    chk("oneshot_idle",   32'(bus.busy), 32'd0);

    // ena dropped two cycles into row 1 drive: the row still completes.
    n_pulses = 0;
    for (int i = 0; i < R + BLANK + 2; i++) step(1'b1, 1'b0);
    for (int i = 0; i < R + 2; i++) step(1'b0, 1'b0);
    chk("abort_drive_a", 32'(bus.a), 32'd1);
    chk("abort_drive_pulses", 32'(n_pulses), 32'd0);

    // ena dropped during the blank before row 2.
    for (int i = 0; i < 2 * R + 1; i++) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("abort_blank_busy", 32'(bus.busy), 32'd0);
    chk("abort_blank_a",    32'(bus.a),    32'd2);
    drain();

    // Asynchronous reset in the middle of row 3 drive, then restart.
    for (int i = 0; i < 3 * R + BLANK + 2; i++) step(1'b1, 1'b0);
    chk("pre_reset_en", 32'(bus.en), 32'd1);
    async_reset();
    step(1'b1, 1'b0);
    chk("restart_a", 32'(bus.a), 32'd0);
    drain();

    // Randomized run with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) async_reset();
      else step($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/decoder_scanner.md
DECODER_SCANNER -- requirements
Module: decoder_scanner

Interface
REQ-001 Parameter N, default 2: width of address output a; legal range 1..8.
REQ-002 Parameter DWELL, default 4: cycles en is held high per address; legal range >=1.
REQ-003 Parameter BLANK, default 1: cycles en is held low between addresses; legal range >=1.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset; one clock, reset async active-low, fixed.
REQ-006 Port ena  input  1  run request; sampled on rising clk.
REQ-007 Port oneshot  input  1  1 = stop after one full frame; sampled at end of last row's DRIVE.
REQ-008 Port a  output  N  registered address to downstream decoder select.
REQ-009 Port en  output  1  registered enable to downstream decoder.
REQ-010 Port frame_done  output  1  registered one-cycle pulse after final address (2^N-1) finishes DRIVE.
REQ-011 Port busy  output  1  high whenever state != IDLE.

Function
REQ-012 FSM states SHALL be exactly IDLE, BLANK, DRIVE; one internal dwell counter, width ceil(log2(max(DWELL,BLANK)))+1.
REQ-013 IDLE: en=0, a holds value; on edge with ena=1 -> BLANK, a<=0, counter<=0.
REQ-014 BLANK: en=0, a stable; counter increments each edge; on edge with counter==BLANK-1 -> DRIVE, en<=1, counter<=0.
REQ-015 BLANK with ena=0 sampled on any edge -> IDLE immediately, counter<=0, no frame_done.
REQ-016 DRIVE: en=1, a stable; counter increments; on edge with counter==DWELL-1: en<=0, counter<=0, then per REQ-017..019.
REQ-017 End of DRIVE, a!=2^N-1: if ena=1 -> BLANK, a<=a+1; if ena=0 -> IDLE, a held.
REQ-018 End of DRIVE, a==2^N-1: frame_done<=1 for exactly one cycle regardless of ena/oneshot.
REQ-019 End of DRIVE, a==2^N-1: if ena=1 and oneshot=0 -> BLANK, a wraps to 0 (mod 2^N); else -> IDLE, a held.
REQ-020 ena=0 during DRIVE SHALL NOT truncate the dwell; current row always completes DWELL cycles.
REQ-021 en high duration SHALL be exactly DWELL cycles; en low gap between consecutive rows exactly BLANK cycles.
REQ-022 a SHALL change only on the edge entering BLANK (or reset); never in a cycle where en=1 or on the edge en rises/falls to 1.
REQ-023 Latency: ena sampled high at edge k in IDLE -> busy=1 after edge k, en first high after edge k+BLANK.
REQ-024 Frame period with ena=1, oneshot=0: 2^N*(DWELL+BLANK) cycles; frame_done period identical.
REQ-025 frame_done SHALL be 0 in all cycles except the one after REQ-018 edge; never asserted on abort.
REQ-026 All outputs SHALL be driven from flops; no combinational path from ena/oneshot to any output.

Reset
REQ-027 rst=0 SHALL asynchronously force state=IDLE, a=0, en=0, frame_done=0, busy=0, counter=0, independent of clk.
REQ-028 Reset asserted mid-DRIVE SHALL drop en to 0 without waiting for a clock edge.
REQ-029 After rst rises, block SHALL remain IDLE until first edge with ena=1.

Verification (N=2, DWELL=4, BLANK=1)
REQ-030 ena=1 held, oneshot=0 -> a sequence 0,1,2,3,0,...; en high 4 cycles, low 1 cycle per row; frame_done pulse every 20 cycles.
REQ-031 ena=1, oneshot=1 -> one frame (20 cycles), single frame_done pulse, then busy=0, en=0, a=3 held.
REQ-032 ena dropped 2 cycles into row 1 DRIVE -> en stays high 4 cycles total, then IDLE, a=1, frame_done never asserted.
REQ-033 ena dropped during BLANK before row 2 -> IDLE on next edge, en never rises for row 2, busy=0.
REQ-034 rst=0 pulsed between clk edges during row 3 DRIVE -> en, a, busy, frame_done all 0 immediately; restart on ena gives a=0.
REQ-035 Bench SHALL check every cycle: a unchanged while en=1, and out-of-range parameters rejected at elaboration.
